// File: rtl/ram_ctrl_if.sv
// Bundles for the ram_ctrl block.
//
// ram_req_if : core-side request/response channel.
//   req_valid  request present (master -> slave)
//   req_ready  slave can accept a request this cycle
//   req_wr     1 = store, 0 = load
//   req_size   0 = 1 byte, 1 = 2 bytes, 2/3 = 4 bytes
//   req_addr   byte address of the lowest byte
//   req_wdata  store data, byte 0 in bits [7:0]
//   resp_valid one-cycle completion pulse
//   resp_rdata load data, zero-extended; 0 for stores
//
// ram_mem_if : byte-wide synchronous RAM port.
//   mem_en     chip enable
//   mem_r_nw   1 = read, 0 = write
//   mem_a      byte address
//   mem_dout   byte to RAM
//   mem_din    byte from RAM (0 whenever mem_en is low)

interface ram_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_wr, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

interface ram_mem_if #(
    parameter int ADDR_WIDTH = 17
);
    logic                  mem_en;
    logic                  mem_r_nw;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic [7:0]            mem_dout;
    logic [7:0]            mem_din;

    modport master (
        output mem_en, mem_r_nw, mem_a, mem_dout,
        input  mem_din
    );

    modport slave (
        input  mem_en, mem_r_nw, mem_a, mem_dout,
        output mem_din
    );
endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl: initiator side of a byte-wide synchronous RAM port.
// Takes one byte/halfword/word load or store per handshake and serialises it
// into consecutive single-byte RAM accesses (little-endian), then returns a
// single-cycle response pulse. All outputs are registered.
//
// Ports:
//   clk_in    system clock, rising edge
//   rst_n_in  asynchronous active-low reset (aborts any transaction)
//   req       ram_req_if.slave  : request/response channel from the core
//   mem       ram_mem_if.master : RAM port (registered read, 1-cycle latency)

module ram_ctrl #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic      clk_in,
    input  logic      rst_n_in,
    ram_req_if.slave  req,
    ram_mem_if.master mem
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        RD_TAIL,
        WR
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            last_q, last_d;      // index of the final byte (N-1)
    logic [1:0]            idx_q, idx_d;        // byte currently on the RAM port
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;    // load assembly buffer
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_r_nw_q, mem_r_nw_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic [1:0]            prev_idx;

    // Size code 3 is treated the same as 2 (a full word).
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            2'd0:    last_index = 2'd0;
            2'd1:    last_index = 2'd1;
            default: last_index = 2'd3;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can
        // leave one unassigned and infer a latch.
        state_d      = state_q;
        last_d       = last_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_en_d     = mem_en_q;
        mem_r_nw_d   = mem_r_nw_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        prev_idx     = idx_q - 2'd1;

        case (state_q)
            IDLE: begin
                if (req.req_valid && req_ready_q) begin
                    state_d     = req.req_wr ? WR : RD;
                    last_d      = last_index(req.req_size);
                    idx_d       = 2'd0;
                    wdata_d     = req.req_wdata;
                    rdata_d     = '0;
                    req_ready_d = 1'b0;
                    // First RAM access is presented in the very next cycle.
                    mem_en_d    = 1'b1;
                    mem_r_nw_d  = ~req.req_wr;
                    mem_a_d     = req.req_addr[ADDR_WIDTH-1:0];
                    mem_dout_d  = req.req_wr ? req.req_wdata[7:0] : 8'h00;
                end
            end

            WR: begin
                if (idx_q == last_q) begin
                    state_d      = IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    mem_en_d     = 1'b0;
                    mem_r_nw_d   = 1'b1;
                    mem_dout_d   = 8'h00;
                end else begin
                    idx_d      = idx_q + 2'd1;
                    // Address wraps naturally at the RAM width.
                    mem_a_d    = mem_a_q + ADDR_WIDTH'(1);
                    mem_dout_d = wdata_q[{idx_d, 3'b000} +: 8];
                end
            end

            RD: begin
                // mem_din carries the byte addressed one cycle earlier.
                if (idx_q != 2'd0) begin
                    rdata_d[{prev_idx, 3'b000} +: 8] = mem.mem_din;
                end
                if (idx_q == last_q) begin
                    // Keep the last address enabled one more cycle to collect its byte.
                    state_d = RD_TAIL;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    mem_a_d = mem_a_q + ADDR_WIDTH'(1);
                end
            end

            RD_TAIL: begin
                rdata_d[{idx_q, 3'b000} +: 8] = mem.mem_din;
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b1;
                resp_rdata_d = rdata_d;
                mem_en_d     = 1'b0;
                mem_r_nw_d   = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            last_q       <= 2'd0;
            idx_q        <= 2'd0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_en_q     <= 1'b0;
            mem_r_nw_q   <= 1'b1;
            mem_a_q      <= '0;
            mem_dout_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_r_nw_q   <= mem_r_nw_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
        end
    end

    assign req.req_ready  = req_ready_q;
    assign req.resp_valid = resp_valid_q;
    assign req.resp_rdata = resp_rdata_q;
    assign mem.mem_en     = mem_en_q;
    assign mem.mem_r_nw   = mem_r_nw_q;
    assign mem.mem_a      = mem_a_q;
    assign mem.mem_dout   = mem_dout_q;

endmodule
